vnu_serial: RTL and testbench
=============================

Name: vnu_serial

Overview:
- Serial variable-node unit for the min-sum LDPC decoder; sits directly downstream of the 7-input check-node unit.
- Per variable node, it takes one channel LLR, then DV check-to-variable messages R.
- It forms the posterior sum and emits DV extrinsic messages Q_i = posterior - R_i, one per handshake, for the next check-node pass.
- It also emits the saturated posterior and a hard-decision bit.

Parameters:
- DATA_W, 32: width of signed LLR, R and Q messages.
- DV, 3: variable-node degree, i.e. R messages per node. Must be >= 2; elaboration fails otherwise.
- IDX_W, $clog2(DV): width of q_idx.
- ACC_W, DATA_W+$clog2(DV+1)+1: internal accumulator width, so no internal overflow.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset.
- llr_valid, input, 1: channel LLR offered.
- llr_ready, output, 1: high only in IDLE.
- llr_in, input, DATA_W: signed channel LLR.
- r_valid, input, 1: check message offered.
- r_ready, output, 1: high only in ACCUM.
- r_in, input, DATA_W: signed check-to-variable message.
- q_valid, output, 1: extrinsic message valid; high only in EMIT.
- q_ready, input, 1: downstream accepts Q.
- q_out, output, DATA_W: signed saturated extrinsic message.
- q_idx, output, IDX_W: edge index 0..DV-1 of q_out.
- post_out, output, DATA_W: saturated posterior of the last completed node.
- hard_bit, output, 1: 1 when the posterior is negative.
- busy, output, 1: high in ACCUM or EMIT.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (immediate, asynchronous):
  - State goes to IDLE; acc, cnt and buf[0..DV-1] clear to 0.
  - post_out = 0, hard_bit = 0, q_valid = 0, q_out = 0, q_idx = 0, busy = 0, llr_ready = 1.
  - Reset mid-operation aborts the node; partial data is discarded.
- States: IDLE -> ACCUM -> EMIT -> IDLE.
- IDLE:
  - llr_ready = 1.
  - On llr_valid & llr_ready: acc <= sign-extended llr_in, cnt <= 0, go to ACCUM.
  - r_valid is ignored.
- ACCUM:
  - r_ready = 1.
  - On r_valid & r_ready: buf[cnt] <= r_in, acc <= acc + sext(r_in), cnt++.
  - On the accept with cnt == DV-1:
    - cnt <= 0, go to EMIT.
    - post_out <= sat(acc_next); hard_bit <= acc_next[ACC_W-1].
  - llr_valid is ignored. Gaps in r_valid are allowed.
- EMIT:
  - q_valid = 1, q_idx = cnt, q_out = sat(acc - sext(buf[cnt])). All derived from registers only; no combinational path from inputs.
  - q_out and q_idx hold stable while q_ready is low.
  - On q_valid & q_ready: cnt++.
  - On the accept with cnt == DV-1: go to IDLE.
- Latency:
  - First Q is valid the cycle after the last R is accepted.
  - With no stalls, a node takes 1 + DV + DV cycles.
  - The next llr can be accepted the cycle after the last Q handshake.
- Saturation sat(x):
  - Clamps to the symmetric range [-(2^(DATA_W-1)-1), +(2^(DATA_W-1)-1)].
  - -2^(DATA_W-1) is never produced, so downstream two's-complement magnitude never overflows.
- post_out and hard_bit:
  - Update only on the ACCUM->EMIT transition.
  - Held through EMIT and IDLE until the next node completes.
- Arithmetic: all add/subtract is signed at ACC_W; no wrap-around is permitted.

Decomposition:
- Shared package ldpc_pkg holds:
  - the DATA_W default;
  - the state enum {IDLE, ACCUM, EMIT};
  - the symmetric-saturation limit constants.
- One sub-module, ldpc_sat: parameterised IN_W -> OUT_W symmetric saturator, instantiated twice (posterior path and Q path).

Test Plan (DV=3, DATA_W=32):
- Basic node: llr=10, R={3,-5,7} -> post_out=15, hard_bit=0, Q idx0..2 = {12,20,8}; first q_valid the cycle after R[2] accepted.
- Negative node: llr=-20, R={4,4,4} -> post_out=-8, hard_bit=1, Q = {-12,-12,-12}.
- Positive saturation: llr=2147483632, R={100,100,100} -> post_out=2147483647; each Q clamps to 2147483647.
- Negative saturation: llr=-2147483647, R={-1,-1,-1} -> post_out=-2147483647; each Q clamps to -2147483647, never 0x80000000.
- Backpressure and gaps:
  - Insert 2 idle cycles between R messages -> result unchanged.
  - Hold q_ready low 5 cycles at idx1 -> q_out=20 and q_idx=1 stable, q_valid high throughout.
- Protocol and reset:
  - r_valid=1 in IDLE -> r_ready=0 and acc unchanged.
  - llr_valid during ACCUM -> not accepted.
  - rst_n low after the idx0 handshake -> same cycle q_valid=0, post_out=0, llr_ready=1.
  - A following clean node (llr=10, R={3,-5,7}) reproduces the basic-node results.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: default message width, variable-node
// FSM states and symmetric saturation limits.
package ldpc_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Symmetric limits for the default width; the most negative code is
  // deliberately excluded so magnitudes never overflow downstream.
  localparam logic signed [DATA_W_DEF-1:0] SAT_POS_DEF = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAT_NEG_DEF = -SAT_POS_DEF;

endpackage

// File: rtl/ldpc_sat.sv
// Symmetric saturator: clamps a signed IN_W value into
// [-(2^(OUT_W-1)-1), +(2^(OUT_W-1)-1)].
module ldpc_sat
  import ldpc_pkg::*;
#(
  parameter int IN_W  = DATA_W_DEF + 3,
  parameter int OUT_W = DATA_W_DEF
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  if (IN_W <= OUT_W) begin : g_width_check
    $error("ldpc_sat: IN_W must exceed OUT_W");
  end

  localparam logic signed [IN_W-1:0] POS_LIM = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] NEG_LIM = -POS_LIM;

  // Clamp to the symmetric range, otherwise pass the low bits through.
  always_comb begin
    if (din > POS_LIM) begin
      dout = POS_LIM[OUT_W-1:0];
    end else if (din < NEG_LIM) begin
      dout = NEG_LIM[OUT_W-1:0];
    end else begin
      dout = din[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/vnu_serial.sv
// Serial variable-node unit: accepts one channel LLR and DV check messages,
// forms the posterior, then streams DV extrinsic messages posterior - R_i.
module vnu_serial
  import ldpc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DV     = 3,
  parameter int IDX_W  = $clog2(DV),
  parameter int ACC_W  = DATA_W + $clog2(DV + 1) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              llr_valid,
  output logic              llr_ready,
  input  logic [DATA_W-1:0] llr_in,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_in,
  output logic              q_valid,
  input  logic              q_ready,
  output logic [DATA_W-1:0] q_out,
  output logic [IDX_W-1:0]  q_idx,
  output logic [DATA_W-1:0] post_out,
  output logic              hard_bit,
  output logic              busy
);

  if (DV < 2) begin : g_dv_check
    $error("vnu_serial: DV must be at least 2");
  end

  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DV - 1);

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]         r_buf_q [DV];
  logic [DATA_W-1:0]         r_buf_d [DV];
  logic [DATA_W-1:0]         post_q, post_d;
  logic                      hard_q, hard_d;

  logic signed [ACC_W-1:0]   llr_ext;
  logic signed [ACC_W-1:0]   r_ext;
  logic signed [ACC_W-1:0]   buf_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   q_diff;
  logic signed [DATA_W-1:0]  post_sat;
  logic signed [DATA_W-1:0]  q_sat;
  logic                      r_take;
  logic                      q_take;

  // Sign extension of the incoming and buffered messages to accumulator width.
  always_comb begin
    llr_ext = {{(ACC_W-DATA_W){llr_in[DATA_W-1]}}, llr_in};
    r_ext   = {{(ACC_W-DATA_W){r_in[DATA_W-1]}}, r_in};
    buf_ext = {{(ACC_W-DATA_W){r_buf_q[cnt_q][DATA_W-1]}}, r_buf_q[cnt_q]};
    acc_sum = acc_q + r_ext;
    q_diff  = acc_q - buf_ext;
  end

  ldpc_sat #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_sat_post (
    .din  (acc_sum),
    .dout (post_sat)
  );

  ldpc_sat #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_sat_q (
    .din  (q_diff),
    .dout (q_sat)
  );

  // Handshake strobes are qualified by the registered state only.
  always_comb begin
    r_take = (state_q == ACCUM) && r_valid;
    q_take = (state_q == EMIT) && q_ready;
  end

  // Each buffer slot captures r_in when it is the slot being filled.
  for (genvar gi = 0; gi < DV; gi++) begin : g_buf
    always_comb begin
      r_buf_d[gi] = r_buf_q[gi];
      if (r_take && (cnt_q == IDX_W'(gi))) begin
        r_buf_d[gi] = r_in;
      end
    end
  end

  // Next-state logic for the IDLE -> ACCUM -> EMIT sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    post_d  = post_q;
    hard_d  = hard_q;
    case (state_q)
      IDLE: begin
        if (llr_valid) begin
          acc_d   = llr_ext;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (r_take) begin
          acc_d = acc_sum;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = EMIT;
            post_d  = post_sat;
            hard_d  = acc_sum[ACC_W-1];
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      EMIT: begin
        if (q_take) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with asynchronous clear; a reset mid-node drops all data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      post_q  <= '0;
      hard_q  <= 1'b0;
      for (int i = 0; i < DV; i++) begin
        r_buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      post_q  <= post_d;
      hard_q  <= hard_d;
      for (int i = 0; i < DV; i++) begin
        r_buf_q[i] <= r_buf_d[i];
      end
    end
  end

  // Outputs depend on registers only, so they are glitch-free of the inputs.
  always_comb begin
    llr_ready = (state_q == IDLE);
    r_ready   = (state_q == ACCUM);
    q_valid   = (state_q == EMIT);
    busy      = (state_q == ACCUM) || (state_q == EMIT);
    q_out     = q_sat;
    q_idx     = cnt_q;
    post_out  = post_q;
    hard_bit  = hard_q;
  end

endmodule

// File: tb/tb_vnu_serial.sv
// Directed bench for vnu_serial (DATA_W=32, DV=3).
module tb_vnu_serial;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               llr_valid;
  logic               llr_ready;
  logic signed [31:0] llr_in;
  logic               r_valid;
  logic               r_ready;
  logic signed [31:0] r_in;
  logic               q_valid;
  logic               q_ready;
  logic signed [31:0] q_out;
  logic [1:0]         q_idx;
  logic signed [31:0] post_out;
  logic               hard_bit;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  vnu_serial #(.DATA_W(32), .DV(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .llr_valid (llr_valid),
    .llr_ready (llr_ready),
    .llr_in    (llr_in),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_in      (r_in),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q_out     (q_out),
    .q_idx     (q_idx),
    .post_out  (post_out),
    .hard_bit  (hard_bit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic signed [31:0] llr;
    logic signed [31:0] r [3];
    int                 gap;
    logic signed [31:0] post;
    logic               hard;
    logic signed [31:0] q [3];
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer the LLR and wait (bounded) until it is taken.
  task automatic send_llr(input logic signed [31:0] v);
    int n = 0;
    llr_valid = 1'b1;
    llr_in    = v;
    while (!llr_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("llr_timeout", 1, 0);
    tick();
    llr_valid = 1'b0;
  endtask

  task automatic send_r(input logic signed [31:0] v, input int gap);
    int n = 0;
    r_valid = 1'b1;
    r_in    = v;
    while (!r_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("r_timeout", 1, 0);
    tick();
    r_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  // Check and accept one Q beat at the expected index.
  task automatic take_q(input string tag, input int idx, input logic signed [31:0] exp);
    chk({tag, "_qvalid"}, q_valid, 1);
    chk({tag, "_qidx"}, q_idx, idx);
    chk({tag, "_qout"}, q_out, exp);
    $display("node %s: q_idx=%0d q_out=%0d", tag, q_idx, q_out);
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    send_llr(v.llr);
    chk({v.name, "_busy"}, busy, 1);
    for (int i = 0; i < 3; i++) send_r(v.r[i], (i < 2) ? v.gap : 0);
    // Right after the last R accept: Q must already be valid.
    chk({v.name, "_post"}, post_out, v.post);
    chk({v.name, "_hard"}, hard_bit, v.hard);
    for (int i = 0; i < 3; i++) take_q(v.name, i, v.q[i]);
    chk({v.name, "_llr_ready_after"}, llr_ready, 1);
    $display("node %s: llr=%0d post=%0d hard=%0d", v.name, v.llr, post_out, hard_bit);
  endtask

  initial begin
    vecs[0] = '{"basic",  32'sd10,          '{32'sd3, -32'sd5, 32'sd7},       0, 32'sd15,          1'b0, '{32'sd12, 32'sd20, 32'sd8}};
    vecs[1] = '{"neg",    -32'sd20,         '{32'sd4, 32'sd4, 32'sd4},        0, -32'sd8,          1'b1, '{-32'sd12, -32'sd12, -32'sd12}};
    vecs[2] = '{"possat", 32'sd2147483632,  '{32'sd100, 32'sd100, 32'sd100},  0, 32'sd2147483647,  1'b0, '{32'sd2147483647, 32'sd2147483647, 32'sd2147483647}};
    vecs[3] = '{"negsat", -32'sd2147483647, '{-32'sd1, -32'sd1, -32'sd1},     0, -32'sd2147483647, 1'b1, '{-32'sd2147483647, -32'sd2147483647, -32'sd2147483647}};
    vecs[4] = '{"gaps",   32'sd10,          '{32'sd3, -32'sd5, 32'sd7},       2, 32'sd15,          1'b0, '{32'sd12, 32'sd20, 32'sd8}};

    rst_n = 1'b0; llr_valid = 1'b0; llr_in = '0;
    r_valid = 1'b0; r_in = '0; q_ready = 1'b0;
    repeat (3) tick();
    chk("rst_llr_ready", llr_ready, 1);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_post", post_out, 0);
    chk("rst_hard", hard_bit, 0);
    chk("rst_q_out", q_out, 0);
    chk("rst_q_idx", q_idx, 0);
    $display("reset: llr_ready=%0d busy=%0d post=%0d", llr_ready, busy, post_out);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // r_valid in IDLE is ignored; the following node must be unaffected.
    r_valid = 1'b1; r_in = 32'sd1000;
    for (int c = 0; c < 3; c++) begin
      chk("idle_r_ready", r_ready, 0);
      chk("idle_busy", busy, 0);
      tick();
    end
    r_valid = 1'b0;
    $display("seq idle_r: r_valid held 3 cycles in IDLE");
    run_vec(vecs[0]);

    // llr_valid during ACCUM is ignored; plus q_ready backpressure at idx1.
    send_llr(32'sd10);
    llr_valid = 1'b1; llr_in = 32'sd999;
    for (int c = 0; c < 2; c++) begin
      chk("accum_llr_ready", llr_ready, 0);
      chk("accum_busy", busy, 1);
      tick();
    end
    llr_valid = 1'b0;
    send_r(32'sd3, 0);
    send_r(-32'sd5, 0);
    send_r(32'sd7, 0);
    chk("bp_post", post_out, 15);
    take_q("bp", 0, 32'sd12);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", q_valid, 1);
      chk("bp_hold_idx", q_idx, 1);
      chk("bp_hold_qout", q_out, 20);
      tick();
    end
    $display("seq backpressure: held q_ready low 5 cycles at idx1");
    take_q("bp", 1, 32'sd20);
    take_q("bp", 2, 32'sd8);

    // Asynchronous reset after the idx0 handshake aborts the node.
    send_llr(-32'sd20);
    send_r(32'sd4, 0);
    send_r(32'sd4, 0);
    send_r(32'sd4, 0);
    take_q("rst", 0, -32'sd12);
    rst_n = 1'b0;
    #1;
    chk("arst_q_valid", q_valid, 0);
    chk("arst_post", post_out, 0);
    chk("arst_hard", hard_bit, 0);
    chk("arst_llr_ready", llr_ready, 1);
    chk("arst_busy", busy, 0);
    $display("seq reset: mid-EMIT reset q_valid=%0d post=%0d", q_valid, post_out);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
